// File: rtl/serial_to_parallel_receiver.sv
`default_nettype none
// ============================================================================
// Module   : serial_to_parallel_receiver
// Brief    : Shifts in an N-bit word (MSB- or LSB-first per frame) and presents
//            it through a valid/ready output buffer with a sticky overrun flag.
//            Optional even-parity bit per frame when PARITY_CHECK_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module serial_to_parallel_receiver #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         dir,
    input  logic         bit_valid,
    input  logic         serial_in,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [N-1:0] parallel_out,
    output logic         busy,
    output logic         overrun,
    output logic         parity_err
);

    localparam int             CW     = $clog2(N + 1);
    localparam logic [CW-1:0]  C_LAST = CW'(N - 1);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1} state_t;
`endif

    state_t          r_state;
    logic [N-1:0]    r_sh;
    logic [CW-1:0]   r_count;
    logic            r_dir_q;
    logic            r_out_valid;
    logic [N-1:0]    r_parallel;
    logic            r_overrun;

    logic [N-1:0]    w_shifted;
    logic [N-1:0]    w_first;
    logic [N-1:0]    w_word;
    logic            w_done;
`ifdef PARITY_CHECK_EN
    logic            r_parity_err;
    logic            w_par;
`endif

    always_comb begin
        w_shifted = r_dir_q ? {r_sh[N-2:0], serial_in} : {serial_in, r_sh[N-1:1]};
        // First bit of a frame lands in a cleared register so no stale bits survive a restart
        w_first   = dir ? {{(N-1){1'b0}}, serial_in} : {serial_in, {(N-1){1'b0}}};
        w_done    = 1'b0;
        w_word    = w_shifted;
`ifdef PARITY_CHECK_EN
        w_par     = ^{r_sh, serial_in};
        if (!start && bit_valid && r_state == S_PARITY) begin
            w_done = 1'b1;
            w_word = r_sh;
        end
`else
        if (!start && bit_valid && r_state == S_SHIFT && r_count == C_LAST) begin
            w_done = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sh        <= '0;
            r_count     <= '0;
            r_dir_q     <= 1'b0;
            r_out_valid <= 1'b0;
            r_parallel  <= '0;
            r_overrun   <= 1'b0;
`ifdef PARITY_CHECK_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            // start restarts the frame from any state, discarding a partial word
            if (start) begin
                r_state <= S_SHIFT;
                r_dir_q <= dir;
                if (bit_valid) begin
                    r_sh    <= w_first;
                    r_count <= CW'(1);
                end else begin
                    r_sh    <= '0;
                    r_count <= '0;
                end
            end else begin
                case (r_state)
                    S_IDLE: ;
                    S_SHIFT: begin
                        if (bit_valid) begin
                            r_sh <= w_shifted;
                            if (r_count == C_LAST) begin
                                r_count <= '0;
`ifdef PARITY_CHECK_EN
                                r_state <= S_PARITY;
`else
                                r_state <= S_IDLE;
`endif
                            end else begin
                                r_count <= r_count + CW'(1);
                            end
                        end
                    end
`ifdef PARITY_CHECK_EN
                    S_PARITY: begin
                        if (bit_valid) begin
                            r_state <= S_IDLE;
                        end
                    end
`endif
                    default: r_state <= S_IDLE;
                endcase
            end

            if (w_done) begin
                if (!r_out_valid || out_ready) begin
                    r_parallel  <= w_word;
                    r_out_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
                    r_parity_err <= w_par;
`endif
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign parallel_out = r_parallel;
    assign overrun      = r_overrun;
    assign busy         = (r_state != S_IDLE);
`ifdef PARITY_CHECK_EN
    assign parity_err   = r_parity_err;
`else
    assign parity_err   = 1'b0;
`endif

endmodule
`default_nettype wire
